// File: rtl/scratchmem_dma.sv
// rtl/scratchmem_dma.sv - single-channel block copy/fill bus master for the scratchpad RAM
//
// Purpose: copies N words from src to dst (read then write per word), or
// fills N destination words with a constant. The slave's ack is level-type
// and stays high while select is held, so every access is followed by one
// idle bus cycle before the next one starts.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, abort_i, mode_i      control (mode 0 = copy, 1 = fill)
//   src_adr_i, dst_adr_i          byte addresses (bits [1:0] ignored)
//   count_i, fill_dat_i           word count and fill word
//   busy_o, done_o, err_o         status (done is a pulse, err is sticky)
//   remain_o                      words not yet written
//   cs_o, cyc_o, stb_o, we_o,
//   sel_o, adr_o, dat_o           registered bus request
//   ack_i, dat_i                  slave response
module scratchmem_dma #(
  parameter int unsigned AW      = 32,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          mode_i,
  input  logic [AW-1:0] src_adr_i,
  input  logic [AW-1:0] dst_adr_i,
  input  logic [CW-1:0] count_i,
  input  logic [31:0]   fill_dat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [CW-1:0] remain_o,
  output logic          cs_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [3:0]    sel_o,
  output logic [AW-1:0] adr_o,
  output logic [31:0]   dat_o,
  input  logic          ack_i,
  input  logic [31:0]   dat_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN} state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] remain_q, remain_d;
  logic [31:0]   fill_q, fill_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          abort_pend_q, abort_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          bus_q, bus_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   wdat_q, wdat_d;

  logic          abort_now;
  logic          timeout_hit;
  logic          unused_lowbits;

  // Word alignment: the two low address bits never reach the bus.
  assign unused_lowbits = ^{src_adr_i[1:0], dst_adr_i[1:0]};

  // An abort seen this cycle counts the same as one already pending, so an
  // ack and an abort in the same cycle finish the access and then stop.
  assign abort_now   = abort_pend_q | abort_i;
  assign timeout_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remain_d     = remain_q;
    fill_d       = fill_q;
    data_d       = data_q;
    tmo_d        = tmo_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    bus_d        = bus_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;

    if (busy_q && abort_i) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d       = mode_i;
          src_d        = {src_adr_i[AW-1:2], 2'b00};
          dst_d        = {dst_adr_i[AW-1:2], 2'b00};
          remain_d     = count_i;
          fill_d       = fill_dat_i;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          abort_pend_d = 1'b0;
          tmo_d        = '0;
          if (count_i == '0) begin
            state_d = FIN;
          end else if (mode_i) begin
            state_d = WR;
            bus_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = {dst_adr_i[AW-1:2], 2'b00};
            wdat_d  = fill_dat_i;
          end else begin
            state_d = RD;
            bus_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = {src_adr_i[AW-1:2], 2'b00};
          end
        end
      end

      RD: begin
        if (ack_i) begin
          data_d  = dat_i;
          bus_d   = 1'b0;
          // A read completed under abort skips its write entirely.
          state_d = abort_now ? FIN : GAP;
        end else if (timeout_hit) begin
          bus_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      WR: begin
        if (ack_i) begin
          bus_d    = 1'b0;
          remain_d = remain_q - CW'(1);
          src_d    = src_q + AW'(4);
          dst_d    = dst_q + AW'(4);
          state_d  = (remain_q == CW'(1) || abort_now) ? FIN : GAP;
        end else if (timeout_hit) begin
          bus_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      GAP: begin
        // Select is low for this one cycle so the slave's ack can clear.
        tmo_d = '0;
        if (abort_now) begin
          state_d = FIN;
        end else if (mode_q || !we_q) begin
          // Fill always writes; copy writes right after its read.
          state_d = WR;
          bus_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = dst_q;
          wdat_d  = mode_q ? fill_q : data_q;
        end else begin
          state_d = RD;
          bus_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = src_q;
        end
      end

      FIN: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        bus_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    sel_d = bus_d ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      fill_q       <= '0;
      data_q       <= '0;
      tmo_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bus_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      adr_q        <= '0;
      wdat_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remain_q     <= remain_d;
      fill_q       <= fill_d;
      data_q       <= data_d;
      tmo_q        <= tmo_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      bus_q        <= bus_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign remain_o = remain_q;
  assign cs_o     = bus_q;
  assign cyc_o    = bus_q;
  assign stb_o    = bus_q;
  assign we_o     = we_q;
  assign sel_o    = sel_q;
  assign adr_o    = adr_q;
  assign dat_o    = wdat_q;

endmodule

// File: tb/tb_scratchmem_dma.sv
// tb/tb_scratchmem_dma.sv - scoreboard bench for scratchmem_dma with a 4-cycle-ack slave model
module tb_scratchmem_dma;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] src_adr_i = '0;
  logic [31:0] dst_adr_i = '0;
  logic [15:0] count_i = '0;
  logic [31:0] fill_dat_i = '0;
  logic        ack_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic        busy_o, done_o, err_o;
  logic [15:0] remain_o;
  logic        cs_o, cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;

  scratchmem_dma #(.AW(32), .CW(16), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i),
    .count_i(count_i), .fill_dat_i(fill_dat_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .remain_o(remain_o), .cs_o(cs_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          wcnt = 0;
  int          wr_count = 0;
  bit          slave_dead = 1'b0;
  bit          acc_evt = 1'b0;

  int n, hi, bsy;
  bit got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic exp_push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    acc_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Slave: acks on the 4th cycle of select and holds ack while select stays high.
  initial begin
    forever begin
      @(negedge clk);
      acc_evt = 1'b0;
      if (!cs_o) begin
        wcnt  = 0;
        ack_i = 1'b0;
      end else if (!ack_i) begin
        wcnt++;
        if (!slave_dead && wcnt >= 4) begin
          ack_i   = 1'b1;
          acc_evt = 1'b1;
          if (we_o) begin
            mem[adr_o] = dat_o;
            wr_count++;
          end else begin
            dat_i = mem.exists(adr_o) ? mem[adr_o] : 32'h0;
          end
        end
      end
    end
  end

  // Monitor: pops the expected access at every ack and checks the idle gap.
  initial begin
    acc_t e;
    acc_t g;
    bit   prev_cyc = 1'b0;
    bit   seen = 1'b0;
    int   low_run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (acc_evt) begin
        checks++;
        g.we  = we_o;
        g.adr = adr_o;
        g.dat = we_o ? dat_o : dat_i;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_acc: got we=%0d adr=%h dat=%h expected no access", g.we, g.adr, g.dat);
        end else begin
          e = exp_q.pop_front();
          if (g !== e || sel_o !== 4'hF || !(cs_o && cyc_o && stb_o)) begin
            errors++;
            $display("FAIL bus_acc: got we=%0d adr=%h dat=%h sel=%h cs/cyc/stb=%0d%0d%0d expected we=%0d adr=%h dat=%h sel=f cs/cyc/stb=111",
                     g.we, g.adr, g.dat, sel_o, cs_o, cyc_o, stb_o, e.we, e.adr, e.dat);
          end
        end
      end
      if (!busy_o) begin
        seen = 1'b0;
      end else if (cyc_o) begin
        if (!prev_cyc && seen) chk("gap_len", low_run, 1);
        seen    = 1'b1;
        low_run = 0;
      end else if (seen) begin
        low_run++;
      end
      prev_cyc = cyc_o;
    end
  end

  task automatic do_start(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] c, input logic [31:0] f);
    @(negedge clk);
    mode_i = m; src_adr_i = s; dst_adr_i = d; count_i = c; fill_dat_i = f;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // n counts clock edges from the accepting edge to the edge that raises done_o.
  task automatic wait_done(output int nn, output int hh, output int bb, output bit gg);
    nn = 0; gg = 1'b0;
    hh = cyc_o ? 1 : 0;
    bb = busy_o ? 1 : 0;
    while (!gg && nn < 2000) begin
      @(negedge clk);
      nn++;
      if (cyc_o) hh++;
      if (busy_o) bb++;
      if (done_o) gg = 1'b1;
    end
    chk("done_seen", {31'b0, gg}, 1);
    chk("busy_at_done", {31'b0, busy_o}, 0);
  endtask

  task automatic after_done(input string name);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'b0, done_o}, 0);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_remain", {16'b0, remain_o}, 0);
    chk("rst_bus", {26'b0, cs_o, cyc_o, stb_o, we_o, |sel_o, |adr_o}, 0);
    chk("rst_dat", dat_o, 0);
    rst_ni = 1'b1;

    // Fill 4 words; a stray start mid-transfer must be ignored.
    exp_push(1'b1, 32'h100, 32'hA5A5A5A5);
    exp_push(1'b1, 32'h104, 32'hA5A5A5A5);
    exp_push(1'b1, 32'h108, 32'hA5A5A5A5);
    exp_push(1'b1, 32'h10C, 32'hA5A5A5A5);
    do_start(1'b1, 32'h0, 32'h102, 16'd4, 32'hA5A5A5A5);
    fork
      wait_done(n, hi, bsy, got);
      begin
        repeat (7) @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; dst_adr_i = 32'h900; count_i = 16'd9;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    chk("fill_latency", n, 20);
    chk("fill_remain", {16'b0, remain_o}, 0);
    chk("fill_err", {31'b0, err_o}, 0);
    after_done("fill");

    // Copy 3 words.
    mem[32'h200] = 32'd1; mem[32'h204] = 32'd2; mem[32'h208] = 32'd3;
    exp_push(1'b0, 32'h200, 32'd1); exp_push(1'b1, 32'h300, 32'd1);
    exp_push(1'b0, 32'h204, 32'd2); exp_push(1'b1, 32'h304, 32'd2);
    exp_push(1'b0, 32'h208, 32'd3); exp_push(1'b1, 32'h308, 32'd3);
    do_start(1'b0, 32'h200, 32'h300, 16'd3, 32'h0);
    wait_done(n, hi, bsy, got);
    chk("copy_latency", n, 30);
    chk("copy_mem0", rd_mem(32'h300), 32'd1);
    chk("copy_mem1", rd_mem(32'h304), 32'd2);
    chk("copy_mem2", rd_mem(32'h308), 32'd3);
    chk("copy_remain", {16'b0, remain_o}, 0);
    after_done("copy");

    // Zero count.
    do_start(1'b0, 32'h200, 32'h300, 16'd0, 32'h0);
    wait_done(n, hi, bsy, got);
    chk("zero_latency", n, 1);
    chk("zero_busy_cycles", bsy, 1);
    chk("zero_no_cyc", hi, 0);
    after_done("zero");

    // Timeout: slave never answers.
    slave_dead = 1'b1;
    do_start(1'b1, 32'h0, 32'h600, 16'd5, 32'h55);
    wait_done(n, hi, bsy, got);
    chk("tmo_cyc_cycles", hi, 255);
    chk("tmo_err", {31'b0, err_o}, 1);
    chk("tmo_remain", {16'b0, remain_o}, 5);
    after_done("tmo");
    slave_dead = 1'b0;
    do_start(1'b0, 32'h0, 32'h0, 16'd0, 32'h0);
    chk("err_cleared", {31'b0, err_o}, 0);
    wait_done(n, hi, bsy, got);
    after_done("clr");

    // Abort during the third read of an 8-word copy.
    for (int i = 0; i < 8; i++) mem[32'h400 + 32'(4 * i)] = 32'h11 + 32'(i);
    exp_push(1'b0, 32'h400, 32'h11); exp_push(1'b1, 32'h500, 32'h11);
    exp_push(1'b0, 32'h404, 32'h12); exp_push(1'b1, 32'h504, 32'h12);
    exp_push(1'b0, 32'h408, 32'h13);
    wr_count = 0;
    do_start(1'b0, 32'h400, 32'h500, 16'd8, 32'h0);
    fork
      wait_done(n, hi, bsy, got);
      begin
        int k;
        k = 0;
        while (!(wr_count == 2 && cyc_o && !we_o) && k < 200) begin
          @(negedge clk);
          k++;
        end
        chk("abort_reached_rd3", {31'b0, k < 200}, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
      end
    join
    chk("abort_writes", wr_count, 2);
    chk("abort_remain", {16'b0, remain_o}, 6);
    chk("abort_err", {31'b0, err_o}, 0);
    chk("abort_no_wr3", {31'b0, mem.exists(32'h508)}, 0);
    after_done("abort");

    // Destination address wrap.
    exp_push(1'b1, 32'hFFFFFFFC, 32'h12345678);
    exp_push(1'b1, 32'h00000000, 32'h12345678);
    do_start(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h12345678);
    wait_done(n, hi, bsy, got);
    chk("wrap_mem0", rd_mem(32'h0), 32'h12345678);
    after_done("wrap");

    // Asynchronous reset in the middle of a write.
    do_start(1'b1, 32'h0, 32'h700, 16'd4, 32'hCAFE0000);
    chk("pre_rst_wr", {30'b0, cyc_o, we_o}, 3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_bus", {29'b0, cs_o, cyc_o, stb_o}, 0);
    chk("arst_busy", {31'b0, busy_o}, 0);
    chk("arst_remain", {16'b0, remain_o}, 0);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
      if (i == 2) rst_ni = 1'b1;
    end
    chk("arst_no_done", {31'b0, got}, 0);
    chk("arst_no_write", {31'b0, mem.exists(32'h700)}, 0);
    chk("arst_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
